// File: rtl/mor1kx_wb_ctrl_marocchino_pkg.sv
// Shared types for the MAROCCHINO write-back controller: state encoding,
// FPCSR geometry and the strobe payload captured by the hold buffer.
package mor1kx_wb_ctrl_marocchino_pkg;

  localparam int unsigned OR1K_FPCSR_WIDTH = 12;
  // Exception flag field occupies FPCSR[11:3]; FPEE and round mode are excluded.
  localparam logic [OR1K_FPCSR_WIDTH-1:0] OR1K_FPCSR_FLAG_MASK = 12'hFF8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic                        flag_set;
    logic                        flag_clear;
    logic                        carry_set;
    logic                        carry_clear;
    logic                        overflow_set;
    logic                        overflow_clear;
    logic                        fpcsr_set;
    logic [OR1K_FPCSR_WIDTH-1:0] fpcsr;
  } wb_strobe_t;

  // Set dominates clear; with neither asserted the bit keeps its value.
  function automatic logic sr_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/mor1kx_wb_hold_buf_marocchino.sv
// One-entry buffer holding an execute result and its SR/FPCSR strobes
// while write-back is stalled.
module mor1kx_wb_hold_buf_marocchino
  import mor1kx_wb_ctrl_marocchino_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     clear,
  input  logic [OPERAND_WIDTH-1:0] result_in,
  input  wb_strobe_t               strb_in,
  output logic                     valid,
  output logic [OPERAND_WIDTH-1:0] result,
  output wb_strobe_t               strb
);

  // Clear takes priority so a flush can never leave a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      result <= '0;
      strb   <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      result <= result_in;
      strb   <= strb_in;
    end
  end

endmodule

// File: rtl/mor1kx_wb_ctrl_marocchino.sv
// MAROCCHINO write-back controller: commits execute results into WB and owns
// SR[F], SR[CY], SR[OV] and the sticky FPCSR flags.
module mor1kx_wb_ctrl_marocchino
  import mor1kx_wb_ctrl_marocchino_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter string       FEATURE_OVERFLOW     = "NONE",
  parameter string       FEATURE_CARRY_FLAG   = "ENABLED",
  parameter string       FEATURE_FPU          = "NONE"
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            padv_decode_i,
  input  logic                            pipeline_flush_i,
  input  logic                            wb_stall_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd_adr_i,
  input  logic                            dcod_rf_wb_i,
  input  logic                            exec_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] exec_result_i,
  input  logic                            exec_flag_set_i,
  input  logic                            exec_flag_clear_i,
  input  logic                            exec_carry_set_i,
  input  logic                            exec_carry_clear_i,
  input  logic                            exec_overflow_set_i,
  input  logic                            exec_overflow_clear_i,
  input  logic [OR1K_FPCSR_WIDTH-1:0]     exec_fpcsr_i,
  input  logic                            exec_fpcsr_set_i,
  input  logic                            sr_ove_i,
  output logic                            flag_o,
  output logic                            carry_o,
  output logic                            overflow_o,
  output logic [OR1K_FPCSR_WIDTH-1:0]     fpcsr_flags_o,
  output logic                            padv_wb_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic                            wb_rf_we_o,
  output logic                            wb_except_overflow_o,
  output logic                            exec_busy_o
);

  localparam bit OVF_EN = (FEATURE_OVERFLOW != "NONE");
  localparam bit CY_EN  = (FEATURE_CARRY_FLAG != "NONE");
  localparam bit FPU_EN = (FEATURE_FPU != "NONE");

  wb_state_t state_q, state_d;
  logic      commit_live, commit_hold, commit;
  logic      hold_load, hold_clear, capture;

  logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_q;
  logic                            rf_wb_q;

  wb_strobe_t                      live_strb, hold_strb, cmt_strb;
  logic [OPTION_OPERAND_WIDTH-1:0] hold_result, cmt_result;
  logic                            hold_valid;

  assign live_strb = '{flag_set:       exec_flag_set_i,
                       flag_clear:     exec_flag_clear_i,
                       carry_set:      exec_carry_set_i,
                       carry_clear:    exec_carry_clear_i,
                       overflow_set:   exec_overflow_set_i,
                       overflow_clear: exec_overflow_clear_i,
                       fpcsr_set:      exec_fpcsr_set_i,
                       fpcsr:          exec_fpcsr_i};

  mor1kx_wb_hold_buf_marocchino #(
    .OPERAND_WIDTH (OPTION_OPERAND_WIDTH)
  ) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .result_in (exec_result_i),
    .strb_in   (live_strb),
    .valid     (hold_valid),
    .result    (hold_result),
    .strb      (hold_strb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state and commit decisions; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    commit_live = 1'b0;
    commit_hold = 1'b0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    capture     = 1'b0;
    if (pipeline_flush_i) begin
      state_d    = EMPTY;
      hold_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (padv_decode_i) begin
            state_d = BUSY;
            capture = 1'b1;
          end
        end
        BUSY: begin
          if (exec_valid_i & ~wb_stall_i) begin
            commit_live = 1'b1;
            if (padv_decode_i) capture = 1'b1;
            else               state_d = EMPTY;
          end else if (exec_valid_i) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (~wb_stall_i) begin
            commit_hold = hold_valid;
            hold_clear  = 1'b1;
            state_d     = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign commit      = commit_live | commit_hold;
  assign padv_wb_o   = commit;
  assign exec_busy_o = ((state_q == BUSY) & ~(exec_valid_i & ~wb_stall_i)) | (state_q == HOLD);
  assign cmt_result  = commit_hold ? hold_result : exec_result_i;
  assign cmt_strb    = commit_hold ? hold_strb   : live_strb;

  // Architectural state and WB latches update on the edge closing a commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_o               <= 1'b0;
      carry_o              <= 1'b0;
      overflow_o           <= 1'b0;
      fpcsr_flags_o        <= '0;
      wb_result_o          <= '0;
      wb_rfd_adr_o         <= '0;
      wb_rf_we_o           <= 1'b0;
      wb_except_overflow_o <= 1'b0;
      rfd_q                <= '0;
      rf_wb_q              <= 1'b0;
    end else begin
      wb_rf_we_o           <= 1'b0;
      wb_except_overflow_o <= 1'b0;
      if (commit) begin
        wb_result_o          <= cmt_result;
        wb_rfd_adr_o         <= rfd_q;
        wb_rf_we_o           <= rf_wb_q;
        wb_except_overflow_o <= OVF_EN & cmt_strb.overflow_set & sr_ove_i;
        flag_o               <= sr_next(flag_o, cmt_strb.flag_set, cmt_strb.flag_clear);
        carry_o              <= CY_EN & sr_next(carry_o, cmt_strb.carry_set, cmt_strb.carry_clear);
        overflow_o           <= OVF_EN & sr_next(overflow_o, cmt_strb.overflow_set,
                                                 cmt_strb.overflow_clear);
        if (cmt_strb.fpcsr_set)
          fpcsr_flags_o <= FPU_EN ? (fpcsr_flags_o | (cmt_strb.fpcsr & OR1K_FPCSR_FLAG_MASK))
                                  : '0;
      end
      if (capture) begin
        rfd_q   <= dcod_rfd_adr_i;
        rf_wb_q <= dcod_rf_wb_i;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_ctrl_marocchino.sv
// Self-checking bench: transaction-level model checked every cycle plus
// hand-computed directed expectations.
module tb_mor1kx_wb_ctrl_marocchino;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        padv_decode_i, pipeline_flush_i, wb_stall_i;
  logic [4:0]  dcod_rfd_adr_i;
  logic        dcod_rf_wb_i, exec_valid_i;
  logic [31:0] exec_result_i;
  logic        exec_flag_set_i, exec_flag_clear_i, exec_carry_set_i, exec_carry_clear_i;
  logic        exec_overflow_set_i, exec_overflow_clear_i;
  logic [11:0] exec_fpcsr_i;
  logic        exec_fpcsr_set_i, sr_ove_i;
  logic        flag_o, carry_o, overflow_o;
  logic [11:0] fpcsr_flags_o;
  logic        padv_wb_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rfd_adr_o;
  logic        wb_rf_we_o, wb_except_overflow_o, exec_busy_o;

  int n_checks = 0;
  int n_err    = 0;

  mor1kx_wb_ctrl_marocchino #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5),
    .FEATURE_OVERFLOW     ("ENABLED"),
    .FEATURE_CARRY_FLAG   ("ENABLED"),
    .FEATURE_FPU          ("ENABLED")
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .padv_decode_i         (padv_decode_i),
    .pipeline_flush_i      (pipeline_flush_i),
    .wb_stall_i            (wb_stall_i),
    .dcod_rfd_adr_i        (dcod_rfd_adr_i),
    .dcod_rf_wb_i          (dcod_rf_wb_i),
    .exec_valid_i          (exec_valid_i),
    .exec_result_i         (exec_result_i),
    .exec_flag_set_i       (exec_flag_set_i),
    .exec_flag_clear_i     (exec_flag_clear_i),
    .exec_carry_set_i      (exec_carry_set_i),
    .exec_carry_clear_i    (exec_carry_clear_i),
    .exec_overflow_set_i   (exec_overflow_set_i),
    .exec_overflow_clear_i (exec_overflow_clear_i),
    .exec_fpcsr_i          (exec_fpcsr_i),
    .exec_fpcsr_set_i      (exec_fpcsr_set_i),
    .sr_ove_i              (sr_ove_i),
    .flag_o                (flag_o),
    .carry_o               (carry_o),
    .overflow_o            (overflow_o),
    .fpcsr_flags_o         (fpcsr_flags_o),
    .padv_wb_o             (padv_wb_o),
    .wb_result_o           (wb_result_o),
    .wb_rfd_adr_o          (wb_rfd_adr_o),
    .wb_rf_we_o            (wb_rf_we_o),
    .wb_except_overflow_o  (wb_except_overflow_o),
    .exec_busy_o           (exec_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: is an insn in execute, is its finished result parked, and what it carries.
  bit          m_occ = 0, m_held = 0, m_rfwb = 0;
  logic [4:0]  m_rfd = '0;
  logic [31:0] h_res = '0;
  bit          h_fs = 0, h_fc = 0, h_cs = 0, h_cc = 0, h_os = 0, h_oc = 0, h_ps = 0;
  logic [11:0] h_fp = '0;
  bit          e_flag = 0, e_carry = 0, e_ovf = 0, e_exc = 0, e_we = 0;
  logic [11:0] e_fp = '0;
  logic [31:0] e_res = '0;
  logic [4:0]  e_rfd = '0;

  function automatic bit upd(input bit cur, input bit s, input bit c);
    if (s) return 1'b1;
    if (c) return 1'b0;
    return cur;
  endfunction

  task automatic retire(input logic [31:0] res, input bit fs, input bit fc, input bit cs,
                        input bit cc, input bit os, input bit oc, input bit ps,
                        input logic [11:0] fp);
    e_res   = res;
    e_rfd   = m_rfd;
    e_we    = m_rfwb;
    e_exc   = os && sr_ove_i;
    e_flag  = upd(e_flag, fs, fc);
    e_carry = upd(e_carry, cs, cc);
    e_ovf   = upd(e_ovf, os, oc);
    if (ps) e_fp = e_fp | (fp & 12'hFF8);
  endtask

  function automatic bit exp_padv();
    if (pipeline_flush_i) return 1'b0;
    if (m_held) return !wb_stall_i;
    return m_occ && exec_valid_i && !wb_stall_i;
  endfunction

  function automatic bit exp_busy();
    if (m_held) return 1'b1;
    return m_occ && !(exec_valid_i && !wb_stall_i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_occ = 0; m_held = 0; m_rfwb = 0; m_rfd = '0;
      e_flag = 0; e_carry = 0; e_ovf = 0; e_exc = 0; e_we = 0;
      e_fp = '0; e_res = '0; e_rfd = '0;
    end else begin
      e_we  = 0;
      e_exc = 0;
      if (pipeline_flush_i) begin
        m_occ  = 0;
        m_held = 0;
      end else if (m_held) begin
        if (!wb_stall_i) begin
          retire(h_res, h_fs, h_fc, h_cs, h_cc, h_os, h_oc, h_ps, h_fp);
          m_held = 0;
          m_occ  = 0;
        end
      end else if (m_occ) begin
        if (exec_valid_i && !wb_stall_i) begin
          retire(exec_result_i, exec_flag_set_i, exec_flag_clear_i, exec_carry_set_i,
                 exec_carry_clear_i, exec_overflow_set_i, exec_overflow_clear_i,
                 exec_fpcsr_set_i, exec_fpcsr_i);
          m_occ = padv_decode_i;
          if (padv_decode_i) begin m_rfd = dcod_rfd_adr_i; m_rfwb = dcod_rf_wb_i; end
        end else if (exec_valid_i) begin
          m_held = 1;
          h_res = exec_result_i; h_fs = exec_flag_set_i; h_fc = exec_flag_clear_i;
          h_cs = exec_carry_set_i; h_cc = exec_carry_clear_i; h_os = exec_overflow_set_i;
          h_oc = exec_overflow_clear_i; h_ps = exec_fpcsr_set_i; h_fp = exec_fpcsr_i;
        end
      end else if (padv_decode_i) begin
        m_occ  = 1;
        m_rfd  = dcod_rfd_adr_i;
        m_rfwb = dcod_rf_wb_i;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_padv_wb", 32'(padv_wb_o), 32'(exp_padv()));
    chk("m_exec_busy", 32'(exec_busy_o), 32'(exp_busy()));
    chk("m_flag", 32'(flag_o), 32'(e_flag));
    chk("m_carry", 32'(carry_o), 32'(e_carry));
    chk("m_overflow", 32'(overflow_o), 32'(e_ovf));
    chk("m_fpcsr", 32'(fpcsr_flags_o), 32'(e_fp));
    chk("m_wb_result", wb_result_o, e_res);
    chk("m_wb_rfd", 32'(wb_rfd_adr_o), 32'(e_rfd));
    chk("m_wb_we", 32'(wb_rf_we_o), 32'(e_we));
    chk("m_except_ovf", 32'(wb_except_overflow_o), 32'(e_exc));
  end

  always @(posedge clk)
    if (rst_n)
      assert (!(exec_flag_set_i && exec_flag_clear_i) && !(exec_carry_set_i && exec_carry_clear_i)
              && !(exec_overflow_set_i && exec_overflow_clear_i))
      else $error("FAIL illegal_set_clear: both strobes asserted");

  task automatic idle();
    padv_decode_i = 0; pipeline_flush_i = 0; wb_stall_i = 0;
    dcod_rfd_adr_i = '0; dcod_rf_wb_i = 0; exec_valid_i = 0; exec_result_i = '0;
    exec_flag_set_i = 0; exec_flag_clear_i = 0; exec_carry_set_i = 0; exec_carry_clear_i = 0;
    exec_overflow_set_i = 0; exec_overflow_clear_i = 0; exec_fpcsr_i = '0;
    exec_fpcsr_set_i = 0; sr_ove_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic [4:0] rfd, input bit wb);
    idle();
    padv_decode_i = 1; dcod_rfd_adr_i = rfd; dcod_rf_wb_i = wb;
    tick();
  endtask

  initial begin
    idle();
    #1;
    chk("rst_flag", 32'(flag_o), 32'd0);
    chk("rst_wb_result", wb_result_o, 32'd0);
    chk("rst_padv", 32'(padv_wb_o), 32'd0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    // 1-clk add with carry_set
    decode(5'd3, 1);
    idle(); exec_valid_i = 1; exec_result_i = 32'h5; exec_carry_set_i = 1;
    #1; chk("t1_padv", 32'(padv_wb_o), 32'd1);
    tick();
    idle(); #1;
    chk("t1_result", wb_result_o, 32'h5);
    chk("t1_rfd", 32'(wb_rfd_adr_o), 32'd3);
    chk("t1_we", 32'(wb_rf_we_o), 32'd1);
    chk("t1_carry", 32'(carry_o), 32'd1);
    tick();
    #1; chk("t1_we_pulse", 32'(wb_rf_we_o), 32'd0);

    // Stall capture into hold buffer
    decode(5'd9, 1);
    idle(); exec_valid_i = 1; wb_stall_i = 1; exec_result_i = 32'hDEADBEEF; exec_flag_set_i = 1;
    #1; chk("t2_padv0", 32'(padv_wb_o), 32'd0); chk("t2_busy0", 32'(exec_busy_o), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); wb_stall_i = 1;
      #1; chk("t2_hold_busy", 32'(exec_busy_o), 32'd1); chk("t2_hold_padv", 32'(padv_wb_o), 32'd0);
      tick();
    end
    idle();
    #1; chk("t2_release_padv", 32'(padv_wb_o), 32'd1); chk("t2_flag_pre", 32'(flag_o), 32'd0);
    tick();
    #1;
    chk("t2_result", wb_result_o, 32'hDEADBEEF);
    chk("t2_rfd", 32'(wb_rfd_adr_o), 32'd9);
    chk("t2_flag", 32'(flag_o), 32'd1);
    chk("t2_busy_after", 32'(exec_busy_o), 32'd0);
    tick();

    // Back-to-back commits
    decode(5'd4, 1);
    idle(); exec_valid_i = 1; exec_result_i = 32'h11; exec_carry_clear_i = 1;
    padv_decode_i = 1; dcod_rfd_adr_i = 5'd7; dcod_rf_wb_i = 1;
    #1; chk("t3_padv_a", 32'(padv_wb_o), 32'd1); chk("t3_busy_a", 32'(exec_busy_o), 32'd0);
    tick();
    idle(); exec_valid_i = 1; exec_result_i = 32'h22;
    #1;
    chk("t3_padv_b", 32'(padv_wb_o), 32'd1);
    chk("t3_rfd_a", 32'(wb_rfd_adr_o), 32'd4);
    chk("t3_result_a", wb_result_o, 32'h11);
    chk("t3_carry", 32'(carry_o), 32'd0);
    tick();
    idle(); #1;
    chk("t3_rfd_b", 32'(wb_rfd_adr_o), 32'd7);
    chk("t3_result_b", wb_result_o, 32'h22);
    chk("t3_padv_idle", 32'(padv_wb_o), 32'd0);
    tick();

    // Flush while HOLD has a pending flag_clear
    decode(5'd2, 1);
    idle(); exec_valid_i = 1; wb_stall_i = 1; exec_flag_clear_i = 1; exec_result_i = 32'h99;
    tick();
    idle(); pipeline_flush_i = 1; wb_stall_i = 1;
    #1; chk("t4_flush_padv", 32'(padv_wb_o), 32'd0);
    tick();
    idle(); #1;
    chk("t4_flag_kept", 32'(flag_o), 32'd1);
    chk("t4_busy", 32'(exec_busy_o), 32'd0);
    chk("t4_no_we", 32'(wb_rf_we_o), 32'd0);
    tick();
    idle(); pipeline_flush_i = 1; padv_decode_i = 1; dcod_rfd_adr_i = 5'd6; dcod_rf_wb_i = 1;
    tick();
    idle(); exec_valid_i = 1; exec_result_i = 32'h33;
    #1; chk("t4_decode_dropped", 32'(padv_wb_o), 32'd0); chk("t4_empty_busy", 32'(exec_busy_o), 32'd0);
    tick();

    // Overflow with exception enabled, FPCSR sticky flags
    decode(5'd5, 1);
    idle(); exec_valid_i = 1; exec_result_i = 32'h44; exec_overflow_set_i = 1; sr_ove_i = 1;
    exec_carry_set_i = 1; exec_fpcsr_set_i = 1; exec_fpcsr_i = 12'hFFF;
    tick();
    idle(); #1;
    chk("t5_ovf", 32'(overflow_o), 32'd1);
    chk("t5_exc", 32'(wb_except_overflow_o), 32'd1);
    chk("t5_fpcsr", 32'(fpcsr_flags_o), 32'hFF8);
    tick();
    #1; chk("t5_exc_pulse", 32'(wb_except_overflow_o), 32'd0);
    decode(5'd8, 1);
    idle(); exec_valid_i = 1; exec_overflow_clear_i = 1; exec_result_i = 32'h55;
    tick();
    idle(); #1; chk("t5_ovf_cleared", 32'(overflow_o), 32'd0);
    decode(5'd8, 0);
    idle(); exec_valid_i = 1; exec_result_i = 32'h66; exec_overflow_set_i = 1; sr_ove_i = 0;
    exec_fpcsr_set_i = 1; exec_fpcsr_i = 12'h001;
    tick();
    idle(); #1;
    chk("t5b_ovf", 32'(overflow_o), 32'd1);
    chk("t5b_no_exc", 32'(wb_except_overflow_o), 32'd0);
    chk("t5b_no_we", 32'(wb_rf_we_o), 32'd0);
    chk("t5b_fpcsr", 32'(fpcsr_flags_o), 32'hFF8);
    tick();

    // Async reset mid-BUSY
    decode(5'd1, 1);
    idle();
    rst_n = 0;
    #1;
    chk("t6_flag", 32'(flag_o), 32'd0);
    chk("t6_carry", 32'(carry_o), 32'd0);
    chk("t6_ovf", 32'(overflow_o), 32'd0);
    chk("t6_fpcsr", 32'(fpcsr_flags_o), 32'd0);
    chk("t6_result", wb_result_o, 32'd0);
    chk("t6_busy", 32'(exec_busy_o), 32'd0);
    tick();
    rst_n = 1;
    tick();
    idle(); exec_valid_i = 1; exec_result_i = 32'h77;
    #1; chk("t6_empty_after", 32'(padv_wb_o), 32'd0);
    tick();
    idle();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
